// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: datapath width, default queue depth and the
// {pc, instr} entry layout carried from fetch to issue.
package if_pkg;

  localparam int unsigned IF_XLEN  = 32;
  localparam int unsigned IF_DEPTH = 8;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with separate occupancy counter, flush, and a
// registered head view that reads zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Flush dominates both push and pop.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= CW'(DEPTH));

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(do_push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue: pairs each synchronous imem read with the PC that produced it,
// buffers the pairs in order and throttles the PC via fq_stall_o.
module instr_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned XLEN  = IF_XLEN,
  parameter int unsigned DEPTH = IF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   pc_hold_i,
  input  logic [XLEN-1:0]        imem_rdata_i,
  input  logic                   flush_i,
  output logic                   fq_stall_o,
  output logic                   issue_valid_o,
  output logic [XLEN-1:0]        issue_pc_o,
  output logic [XLEN-1:0]        issue_instr_o,
  input  logic                   issue_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            pend_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  logic [2*XLEN-1:0] head;

  // pend_q marks that this cycle's imem data belongs to pend_pc_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= ~pc_hold_i & ~flush_i;
      pend_pc_q <= pc_i;
    end
  end

  assign push = pend_q & ~flush_i;
  assign pop  = issue_valid_o & issue_ready_i;

  // Counts the in-flight fetch and ignores same-cycle pops, so a push never
  // lands on a full FIFO and nothing depends on pc_hold_i combinationally.
  assign fq_stall_o = (({1'b0, count} + {{CW{1'b0}}, pend_q}) >= (CW+1)'(DEPTH));

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pend_pc_q, imem_rdata_i}),
    .pop       (pop),
    .flush     (flush_i),
    .count     (count),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign issue_valid_o = ~fifo_empty;
  assign issue_pc_o    = head[2*XLEN-1:XLEN];
  assign issue_instr_o = head[XLEN-1:0];
  assign count_o       = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: models the PC register and a
// synchronous imem around the DUT and checks every issued entry in order.
module tb_instr_fetch_queue;
  import if_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pc_hold_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        fq_stall_o;
  logic        issue_valid_o;
  logic [31:0] issue_pc_o;
  logic [31:0] issue_instr_o;
  logic        issue_ready_i;
  logic [3:0]  count_o;

  logic ext_hold;
  logic flush_req;
  logic ready;
  logic hold_r;
  logic model_pend;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pops_10;
  fq_entry_t sb[$];

  instr_fetch_queue #(
    .XLEN  (32),
    .DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc_i),
    .pc_hold_i     (pc_hold_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .fq_stall_o    (fq_stall_o),
    .issue_valid_o (issue_valid_o),
    .issue_pc_o    (issue_pc_o),
    .issue_instr_o (issue_instr_o),
    .issue_ready_i (issue_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    pc_i          = '0;
    imem_rdata_i  = '0;
    pc_hold_i     = 1'b0;
    flush_i       = 1'b0;
    issue_ready_i = 1'b0;
    ext_hold      = 1'b0;
    flush_req     = 1'b0;
    ready         = 1'b0;
    model_pend    = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_count", count_o, 0);
    chk("rst_valid", issue_valid_o, 0);
    chk("rst_pc", issue_pc_o, 0);
    chk("rst_instr", issue_instr_o, 0);
    chk("rst_stall", fq_stall_o, 0);
  endtask

  // One clock: drive, check against the model, advance the edge, then update
  // the PC register and imem models.
  task automatic cycle();
    fq_entry_t e;
    int        in_fifo;
    hold_r        = fq_stall_o | ext_hold;
    pc_hold_i     = hold_r;
    flush_i       = flush_req;
    issue_ready_i = ready;
    in_fifo = sb.size() - (model_pend ? 1 : 0);
    chk("count", count_o, 64'(in_fifo));
    chk("valid", issue_valid_o, 64'(in_fifo != 0));
    chk("stall", fq_stall_o, 64'(sb.size() >= 8));
    if (issue_valid_o && ready && !flush_req) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", issue_valid_o, 0);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", issue_pc_o, 64'(e.pc));
        chk("pop_instr", issue_instr_o, 64'(e.instr));
        if (issue_pc_o == 32'h10) pops_10++;
      end
    end
    if (flush_req) sb.delete();
    model_pend = !hold_r && !flush_req;
    if (model_pend) sb.push_back('{pc: pc_i, instr: pc_i ^ KEY});
    @(posedge clk);
    #1;
    imem_rdata_i = pc_i ^ KEY;
    if (!hold_r) pc_i = pc_i + 32'd4;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // 1: free-running fetch with a ready consumer
    do_reset();
    ready = 1'b1;
    cycle();
    cycle();
    chk("s1_first_valid", issue_valid_o, 1);
    chk("s1_first_pc", issue_pc_o, 0);
    chk("s1_first_instr", issue_instr_o, 64'(KEY));
    run(20);

    // 2: consumer stalled, queue fills and holds the PC
    do_reset();
    for (int i = 0; i < 20 && !fq_stall_o; i++) cycle();
    chk("s2_stall_seen", fq_stall_o, 1);
    chk("s2_pc_held", pc_i, 32'h20);
    run(3);
    chk("s2_pc_still", pc_i, 32'h20);
    chk("s2_head", issue_pc_o, 0);
    ready = 1'b1;
    run(20);

    // 3: external hold for three cycles at PC 0x10
    do_reset();
    ready   = 1'b1;
    pops_10 = 0;
    for (int i = 0; i < 20 && pc_i != 32'h10; i++) cycle();
    chk("s3_reach", pc_i, 32'h10);
    ext_hold = 1'b1;
    run(3);
    ext_hold = 1'b0;
    run(12);
    chk("s3_one_entry", 64'(pops_10), 1);

    // 4: flush with five buffered entries and one in flight
    do_reset();
    for (int i = 0; i < 20 && !(count_o == 4'd5 && model_pend); i++) cycle();
    chk("s4_reach", count_o, 5);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    chk("s4_count", count_o, 0);
    chk("s4_valid", issue_valid_o, 0);
    ready = 1'b1;
    run(15);

    // 5: simultaneous push and pop at count 3
    do_reset();
    for (int i = 0; i < 20 && count_o != 4'd3; i++) cycle();
    chk("s5_reach", count_o, 3);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    chk("s5_count", count_o, 3);
    chk("s5_head", issue_pc_o, 32'h4);
    ready = 1'b1;
    run(15);

    // 6: asynchronous reset between clock edges while stalled
    do_reset();
    run(9);
    chk("s6_pre_stall", fq_stall_o, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_valid", issue_valid_o, 0);
    chk("s6_stall", fq_stall_o, 0);
    chk("s6_count", count_o, 0);
    sb.delete();
    model_pend   = 1'b0;
    pc_i         = '0;
    imem_rdata_i = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready = 1'b1;
    cycle();
    cycle();
    chk("s6_first_pc", issue_pc_o, 0);
    chk("s6_first_instr", issue_instr_o, 64'(KEY));
    run(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
